// File: rtl/tr_pkg.sv
// Shared definitions for the tracking-controller step chain (TR, TR_pulse, ramp).
package tr_pkg;

  localparam int PW    = 17;    // period width in clk cycles
  localparam int N_MIN = 1000;  // shortest period, 50 kHz at 50 MHz
  localparam int N_MAX = 8333;  // longest period, 6 kHz; start/stop period

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_ACCEL  = 3'd1,
    ST_RUN    = 3'd2,
    ST_DECEL  = 3'd3,
    ST_SETTLE = 3'd4
  } ramp_state_t;

endpackage

// File: rtl/tr_ramp_ctrl_if.sv
// Request/drive bundle between TR, the ramp sequencer and TR_pulse.
interface tr_ramp_ctrl_if;

  logic                   en_req;
  logic                   dir_req;
  logic [tr_pkg::PW-1:0]  n_target;
  logic                   step_done;
  logic [tr_pkg::PW-1:0]  n_out;
  logic                   drv_enable_out;
  logic                   drv_dir_out;
  logic                   busy;
  logic [2:0]             state_dbg;

  // Requesting side: TR plus the step feedback from TR_pulse
  modport master (
    output en_req, dir_req, n_target, step_done,
    input  n_out, drv_enable_out, drv_dir_out, busy, state_dbg
  );

  // The ramp sequencer itself
  modport slave (
    input  en_req, dir_req, n_target, step_done,
    output n_out, drv_enable_out, drv_dir_out, busy, state_dbg
  );

endinterface

// File: rtl/tr_ramp_step.sv
// Saturating one-step move of a period toward a goal by at most STEP_DELTA.
module tr_ramp_step #(
  parameter int PW         = 17,
  parameter int STEP_DELTA = 64
) (
  input  logic [PW-1:0] cur,
  input  logic [PW-1:0] goal,
  output logic [PW-1:0] nxt
);

  logic [PW:0] diff;

  // Distance is taken in PW+1 bits so neither direction can wrap
  always_comb begin
    diff = '0;
    nxt  = cur;
    if (cur > goal) begin
      diff = {1'b0, cur} - {1'b0, goal};
      if (diff <= (PW+1)'(STEP_DELTA)) nxt = goal;
      else                             nxt = cur - PW'(STEP_DELTA);
    end else if (cur < goal) begin
      diff = {1'b0, goal} - {1'b0, cur};
      if (diff <= (PW+1)'(STEP_DELTA)) nxt = goal;
      else                             nxt = cur + PW'(STEP_DELTA);
    end
  end

endmodule

// File: rtl/tr_ramp_ctrl.sv
// Step-rate ramp sequencer: slew-limits TR's period request and forces a full
// stop plus settle delay before any direction reversal.
module tr_ramp_ctrl #(
  parameter int PW         = tr_pkg::PW,
  parameter int N_MIN      = tr_pkg::N_MIN,
  parameter int N_MAX      = tr_pkg::N_MAX,
  parameter int STEP_DELTA = 64,
  parameter int DIR_SETTLE = 500
) (
  input  logic           clk,
  input  logic           rst,
  tr_ramp_ctrl_if.slave  bus
);

  import tr_pkg::*;

  localparam int CW = $clog2(DIR_SETTLE + 1);

  ramp_state_t   state_reg, state_next;
  logic [PW-1:0] n_reg, n_next;
  logic          en_reg, en_next;
  logic          dir_reg, dir_next;
  logic [CW-1:0] cnt_reg, cnt_next;

  logic [PW-1:0] tgt;
  logic [PW-1:0] goal;
  logic [PW-1:0] step_n;
  logic          run_ok;
  logic          stop_now;

  // Clamp the request and pick the goal; a stop or reversal heads for N_MAX
  always_comb begin
    if (bus.n_target < PW'(N_MIN))      tgt = PW'(N_MIN);
    else if (bus.n_target > PW'(N_MAX)) tgt = PW'(N_MAX);
    else                                tgt = bus.n_target;
    run_ok   = bus.en_req && (bus.dir_req == dir_reg);
    goal     = run_ok ? tgt : PW'(N_MAX);
    stop_now = !run_ok && (n_reg == PW'(N_MAX));
  end

  tr_ramp_step #(
    .PW         (PW),
    .STEP_DELTA (STEP_DELTA)
  ) u_step (
    .cur  (n_reg),
    .goal (goal),
    .nxt  (step_n)
  );

  // State and datapath registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg <= ST_IDLE;
      n_reg     <= PW'(N_MAX);
      en_reg    <= 1'b0;
      dir_reg   <= 1'b0;
      cnt_reg   <= '0;
    end else begin
      state_reg <= state_next;
      n_reg     <= n_next;
      en_reg    <= en_next;
      dir_reg   <= dir_next;
      cnt_reg   <= cnt_next;
    end
  end

  // Next-state logic: start, per-step slew, stop detection and settle countdown
  always_comb begin
    state_next = state_reg;
    n_next     = n_reg;
    en_next    = en_reg;
    dir_next   = dir_reg;
    cnt_next   = cnt_reg;
    case (state_reg)
      ST_IDLE: begin
        if (bus.en_req) begin
          dir_next   = bus.dir_req;
          en_next    = 1'b1;
          state_next = (tgt < PW'(N_MAX)) ? ST_ACCEL : ST_RUN;
        end
      end
      ST_ACCEL, ST_RUN, ST_DECEL: begin
        if (stop_now) begin
          en_next = 1'b0;
          if (!bus.en_req) begin
            state_next = ST_IDLE;
          end else begin
            state_next = ST_SETTLE;
            cnt_next   = CW'(DIR_SETTLE - 1);
          end
        end else begin
          if (bus.step_done) n_next = step_n;
          // Larger period than goal means still speeding up
          if (n_next > goal)      state_next = ST_ACCEL;
          else if (n_next < goal) state_next = ST_DECEL;
          else                    state_next = ST_RUN;
        end
      end
      ST_SETTLE: begin
        if (cnt_reg == '0) begin
          dir_next   = bus.dir_req;
          state_next = ST_IDLE;
        end else begin
          cnt_next = cnt_reg - 1'b1;
        end
      end
      default: state_next = ST_IDLE;
    endcase
  end

  // Outputs straight from registers
  always_comb begin
    bus.n_out          = n_reg;
    bus.drv_enable_out = en_reg;
    bus.drv_dir_out    = dir_reg;
    bus.busy           = (state_reg != ST_IDLE);
    bus.state_dbg      = state_reg;
  end

endmodule

// File: doc/tr_ramp_ctrl.md
# tr_ramp_ctrl

Step-rate ramp sequencer between the tracking controller (TR) and the step-pulse generator (TR_pulse). It takes TR's requested step period, enable and direction, and delivers a slew-limited period, a gated enable and a direction to TR_pulse. The period changes by at most one increment per emitted step. A direction reversal always passes through a full stop and a settle delay, so the motor never reverses at speed.

## Interface
Parameters:
- PW, 17: period width in clk cycles.
- N_MIN, 1000: shortest allowed period (50 kHz at 50 MHz).
- N_MAX, 8333: longest allowed period (6 kHz); also the start/stop period.
- STEP_DELTA, 64: maximum period change per step.
- DIR_SETTLE, 500: cycles the drive stays disabled before a reversed restart.

Ports:
- clk, in, 1: 50 MHz system clock. One clock domain.
- rst, in, 1: reset, synchronous, active-high.
- en_req, in, 1: run request from TR (drv_enable_SM).
- dir_req, in, 1: requested direction from TR.
- n_target, in, PW: requested period from TR (N).
- step_done, in, 1: one-cycle pulse, one per step emitted by TR_pulse.
- n_out, out, PW: period to TR_pulse.
- drv_enable_out, out, 1: enable to TR_pulse.
- drv_dir_out, out, 1: direction to the driver.
- busy, out, 1: high in any state other than IDLE.
- state_dbg, out, 3: state code.

## Operation
- Reset values:
  - n_out=N_MAX, drv_enable_out=0, drv_dir_out=0, busy=0.
  - State IDLE, settle counter 0.
  - A reset during any state returns to these values on the next edge, with no ramp-down.
- Target clamp, combinational: tgt = min(max(n_target, N_MIN), N_MAX).
- goal (combinational):
  - goal = tgt when en_req=1 and dir_req==drv_dir_out.
  - goal = N_MAX otherwise. This is a stop or reversal request.
- States: IDLE=0, ACCEL=1, RUN=2, DECEL=3, SETTLE=4.
- IDLE, on en_req=1:
  - drv_dir_out←dir_req, drv_enable_out←1, n_out stays N_MAX.
  - Next state is ACCEL if tgt<N_MAX, otherwise RUN.
- ACCEL / RUN / DECEL, on step_done=1:
  - n_out moves toward goal by STEP_DELTA and saturates at goal; it never overshoots.
  - Downward move: if n_out−goal ≤ STEP_DELTA, n_out←goal. Compute in PW+1 bits; no underflow.
  - Upward move is symmetric.
- State label after each update: n_out>goal → ACCEL, n_out<goal → DECEL, equal → RUN. Labels are re-evaluated every cycle from the current goal.
- Stop condition, checked every cycle including cycles with no step_done:
  - Condition: goal==N_MAX, a stop/reversal is pending, and n_out==N_MAX.
  - Action: drv_enable_out←0.
  - If en_req=0, go to IDLE.
  - If en_req=1 with the opposite direction, go to SETTLE and load the counter with DIR_SETTLE−1.
- SETTLE:
  - Count down to 0, then drv_dir_out←dir_req and go to IDLE. Restart follows the normal IDLE path.
  - A step_done arriving in SETTLE is ignored.
- step_done in IDLE or SETTLE: ignored.
- n_target changing mid-ramp: the new goal takes effect on the next step; no restart.

## Timing
- n_out updates on the clock edge where step_done is sampled high. TR_pulse sees the new period one cycle after the pulse.
- IDLE→enabled: drv_enable_out and drv_dir_out rise on the first edge where en_req=1 is sampled.
- Stop: drv_enable_out falls on the edge after the step that brings n_out to N_MAX. If n_out is already N_MAX, it falls on the next edge.
- Minimum reversal gap: DIR_SETTLE+1 cycles with drv_enable_out=0 before re-enable.
- Simultaneous events:
  - rst wins over everything.
  - A goal change and step_done in the same cycle: the step uses that same cycle's goal.
- drv_dir_out never changes while drv_enable_out=1.

## Structure
- The shared package tr_pkg holds:
  - the period width PW
  - N_MIN and N_MAX
  - the state encoding
- These are shared with TR and TR_pulse.
- One sub-module, tr_ramp_step: a combinational saturating step of n_out toward goal by STEP_DELTA. It is reusable for a future acceleration profile.
- The FSM and settle counter live in tr_ramp_ctrl.

## Test plan
- Reset: hold rst for 3 cycles → n_out=8333, drv_enable_out=0, drv_dir_out=0, busy=0, state_dbg=0.
- Accel:
  - Stimulus: en_req=1, dir_req=1, n_target=8000, step_done every 5 cycles.
  - Expected: enable and dir=1 one cycle after en_req.
  - Expected n_out per step: 8269, 8205, 8141, 8077, 8013, 8000, then state RUN.
- Clamp: n_target=500 from RUN at 8000 → n_out descends by 64 per step to 1000 exactly and never goes below it.
- Reversal:
  - Stimulus: at RUN 8000 with dir=1, set dir_req=0.
  - Expected n_out per step: 8064, 8128, 8192, 8256, 8320, 8333.
  - Then enable drops for 501 cycles, drv_dir_out=0, re-enable, and the ramp restarts.
- Stop:
  - Stimulus: drop en_req at RUN 8000; ramp up to 8333; enable drops; state IDLE.
  - Expected: a later step_done leaves n_out unchanged.
- Mid-ramp reset: assert rst during ACCEL at n_out=8141 → next edge n_out=8333, enable=0, IDLE.
